// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: writeback-select codes, state
// encoding, widths and the writeback result mux.
package wb_pkg;

  localparam int REG_SEL_W = 3;
  localparam int DATA_W    = 16;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC  = 2'b10;
  localparam logic [1:0] WBSEL_IMM = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

  function automatic logic [DATA_W-1:0] wb_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] pcinc,
    input logic [DATA_W-1:0] imm
  );
    logic [DATA_W-1:0] res;
    case (sel)
      WBSEL_ALU: res = alu;
      WBSEL_MEM: res = mem;
      WBSEL_PC:  res = pcinc;
      WBSEL_IMM: res = imm;
      default:   res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_fwd.sv
// Per-read-port bypass of the writeback value into decode.
// The compare is built only when WB_BYPASS_EN is defined; otherwise a pass-through.
module wb_fwd
  import wb_pkg::*;
(
  input  logic                 write,
  input  logic [REG_SEL_W-1:0] writeregsel,
  input  logic [DATA_W-1:0]    writedata,
  input  logic [REG_SEL_W-1:0] readregsel,
  input  logic [DATA_W-1:0]    rf_data,
  output logic [DATA_W-1:0]    fwd_data
);

`ifdef WB_BYPASS_EN
  assign fwd_data = (write && (writeregsel == readregsel)) ? writedata : rf_data;
`else
  logic unused_s;
  assign unused_s = ^{write, writeregsel, writedata, readregsel};
  assign fwd_data = rf_data;
`endif

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback controller with halt tracking,
// saturating retire counter and optional bypass (WB_BYPASS_EN).
module wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    in_alu,
  input  logic [DATA_W-1:0]    in_mem,
  input  logic [DATA_W-1:0]    in_pcinc,
  input  logic [DATA_W-1:0]    in_imm,
  input  logic [1:0]           in_wbsel,
  input  logic [REG_SEL_W-1:0] in_dest,
  input  logic                 in_regwrite,
  input  logic                 in_halt,
  input  logic [REG_SEL_W-1:0] read1regsel,
  input  logic [REG_SEL_W-1:0] read2regsel,
  input  logic [DATA_W-1:0]    rf_read1data,
  input  logic [DATA_W-1:0]    rf_read2data,
  output logic [REG_SEL_W-1:0] writeregsel,
  output logic [DATA_W-1:0]    writedata,
  output logic                 write,
  output logic [DATA_W-1:0]    fwd_read1data,
  output logic [DATA_W-1:0]    fwd_read2data,
  output logic                 wb_valid,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired,
  output logic                 err
);

  logic                 valid_q;
  logic [DATA_W-1:0]    alu_q, mem_q, pcinc_q, imm_q;
  logic [1:0]           wbsel_q;
  logic [REG_SEL_W-1:0] dest_q;
  logic                 regwrite_q;
  logic                 halt_q;
  wb_state_e            state_q;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic                 err_q;
  logic                 retire_s;

  assign retire_s = valid_q & ~stall & (state_q == ST_RUN);

  // Saturating retire count: stays at all-ones rather than wrapping.
  always_comb begin
    retired_d = retired_q;
    if (retire_s && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_q      <= {DATA_W{1'b0}};
      mem_q      <= {DATA_W{1'b0}};
      pcinc_q    <= {DATA_W{1'b0}};
      imm_q      <= {DATA_W{1'b0}};
      wbsel_q    <= 2'b00;
      dest_q     <= {REG_SEL_W{1'b0}};
      regwrite_q <= 1'b0;
      halt_q     <= 1'b0;
      state_q    <= ST_RUN;
      retired_q  <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      retired_q <= retired_d;
      if ((state_q == ST_HALT) && in_valid) begin
        err_q <= 1'b1;
      end
      if (retire_s && halt_q) begin
        state_q <= ST_HALT;
      end
      // Flush beats stall; with both set the held instruction is dropped.
      if (flush) begin
        valid_q <= 1'b0;
      end else if (stall) begin
        valid_q <= valid_q;
      end else if (state_q == ST_RUN) begin
        valid_q    <= in_valid;
        alu_q      <= in_alu;
        mem_q      <= in_mem;
        pcinc_q    <= in_pcinc;
        imm_q      <= in_imm;
        wbsel_q    <= in_wbsel;
        dest_q     <= in_dest;
        regwrite_q <= in_regwrite;
        halt_q     <= in_halt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid    = retire_s;
  assign write       = retire_s & regwrite_q;
  assign writeregsel = dest_q;
  assign writedata   = wb_mux(wbsel_q, alu_q, mem_q, pcinc_q, imm_q);
  assign halted      = (state_q == ST_HALT);
  assign retired     = retired_q;
  assign err         = err_q;

  wb_fwd u_fwd1 (
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .readregsel  (read1regsel),
    .rf_data     (rf_read1data),
    .fwd_data    (fwd_read1data)
  );

  wb_fwd u_fwd2 (
    .write       (write),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .readregsel  (read2regsel),
    .rf_data     (rf_read2data),
    .fwd_data    (fwd_read2data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a slot-level reference model pushes expected
// retirements into a queue, a negedge monitor pops and compares them.
module tb_wb_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk, rst;
  logic        in_valid, stall, flush;
  logic [15:0] in_alu, in_mem, in_pcinc, in_imm;
  logic [1:0]  in_wbsel;
  logic [2:0]  in_dest;
  logic        in_regwrite, in_halt;
  logic [2:0]  read1regsel, read2regsel;
  logic [15:0] rf_read1data, rf_read2data;
  logic [2:0]  writeregsel;
  logic [15:0] writedata, fwd_read1data, fwd_read2data;
  logic        write, wb_valid, halted, err;
  logic [CNT_W-1:0] retired;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_alu(in_alu), .in_mem(in_mem), .in_pcinc(in_pcinc), .in_imm(in_imm),
    .in_wbsel(in_wbsel), .in_dest(in_dest), .in_regwrite(in_regwrite),
    .in_halt(in_halt), .read1regsel(read1regsel), .read2regsel(read2regsel),
    .rf_read1data(rf_read1data), .rf_read2data(rf_read2data),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .fwd_read1data(fwd_read1data), .fwd_read2data(fwd_read2data),
    .wb_valid(wb_valid), .halted(halted), .retired(retired), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
    logic        rw;
    logic        halt;
  } item_t;

  item_t exp_q[$];
  int    nchk = 0;
  int    nerr = 0;

  // Reference model: one pipeline slot plus halt/err/count state.
  bit    pend_v;
  item_t pend;
  bit    halted_m;
  bit    err_m;
  int    cnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t mk_item();
    item_t it;
    it.dest = in_dest;
    it.rw   = in_regwrite;
    it.halt = in_halt;
    case (in_wbsel)
      2'd0:    it.data = in_alu;
      2'd1:    it.data = in_mem;
      2'd2:    it.data = in_pcinc;
      default: it.data = in_imm;
    endcase
    return it;
  endfunction

  function automatic logic [15:0] exp_fwd(input bit hit_w, input item_t it,
                                          input logic [2:0] rsel, input logic [15:0] rfd);
`ifdef WB_BYPASS_EN
    if (hit_w && it.rw && (it.dest == rsel)) return it.data;
`endif
    return rfd;
  endfunction

  // Monitor: compare the presented writeback against the scoreboard head.
  always @(negedge clk) begin
    item_t it;
    it = '{dest: 3'd0, data: 16'd0, rw: 1'b0, halt: 1'b0};
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_retire", 32'(wb_valid), 32'd0);
      end else begin
        it = exp_q.pop_front();
        chk("write", 32'(write), 32'(it.rw));
        chk("writeregsel", 32'(writeregsel), 32'(it.dest));
        chk("writedata", 32'(writedata), 32'(it.data));
        chk("fwd1", 32'(fwd_read1data), 32'(exp_fwd(1'b1, it, read1regsel, rf_read1data)));
        chk("fwd2", 32'(fwd_read2data), 32'(exp_fwd(1'b1, it, read2regsel, rf_read2data)));
      end
    end else begin
      chk("write_idle", 32'(write), 32'd0);
      chk("fwd1_idle", 32'(fwd_read1data), 32'(rf_read1data));
      chk("fwd2_idle", 32'(fwd_read2data), 32'(rf_read2data));
    end
  end

  task automatic set_in(input bit iv, input bit st, input bit fl, input logic [1:0] sel,
                        input logic [2:0] dest, input bit rw, input bit hlt);
    in_valid = iv; stall = st; flush = fl; in_wbsel = sel; in_dest = dest;
    in_regwrite = rw; in_halt = hlt;
    in_alu = 16'($urandom); in_mem = 16'($urandom);
    in_pcinc = 16'($urandom); in_imm = 16'($urandom);
    read1regsel = 3'($urandom); read2regsel = 3'($urandom);
    rf_read1data = 16'($urandom); rf_read2data = 16'($urandom);
  endtask

  // One clock edge: update the model from the inputs held across the edge, then check state.
  task automatic step();
    bit ret, hn;
    @(posedge clk);
    ret = pend_v && !stall && !halted_m;
    hn  = halted_m || (ret && pend.halt);
    if (ret && cnt_m != CMAX) cnt_m++;
    if (halted_m && in_valid) err_m = 1'b1;
    if (flush) begin
      if (pend_v && stall && !halted_m && exp_q.size() > 0) void'(exp_q.pop_back());
      pend_v = 1'b0;
    end else if (stall) begin
      pend_v = pend_v;
    end else if (!halted_m) begin
      pend_v = in_valid;
      pend   = mk_item();
      if (in_valid && !hn) exp_q.push_back(pend);
    end else begin
      pend_v = 1'b0;
    end
    halted_m = hn;
    #1;
    chk("halted", 32'(halted), 32'(halted_m));
    chk("retired", 32'(retired), 32'(cnt_m));
    chk("err", 32'(err), 32'(err_m));
  endtask

  task automatic model_clear();
    pend_v = 1'b0; halted_m = 1'b0; err_m = 1'b0; cnt_m = 0;
    pend = '{dest: 3'd0, data: 16'd0, rw: 1'b0, halt: 1'b0};
    exp_q.delete();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_writeregsel", 32'(writeregsel), 32'd0);
    chk("rst_writedata", 32'(writedata), 32'd0);
    model_clear();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("init_retired", 32'(retired), 32'd0);
    chk("init_write", 32'(write), 32'd0);
    rst = 1'b0;

    // Basic load write: mem data BEEF to r5.
    set_in(1'b1, 1'b0, 1'b0, 2'b01, 3'd5, 1'b1, 1'b0);
    in_mem = 16'hBEEF;
    step();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("basic_retired", 32'(retired), 32'd1);

    // Stall held three cycles on a captured instruction.
    set_in(1'b1, 1'b0, 1'b0, 2'b00, 3'd2, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    step();
    chk("stall_retired", 32'(retired), 32'd2);

    // Flush discards the incoming instruction.
    set_in(1'b1, 1'b0, 1'b1, 2'b10, 3'd6, 1'b1, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    step();

    // Stall+flush loses the held instruction.
    set_in(1'b1, 1'b0, 1'b0, 2'b11, 3'd1, 1'b1, 1'b0);
    step();
    set_in(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    step();

    // Bypass window: r3 <- 1234, decode reading r3 and r4 in the writeback cycle.
    set_in(1'b1, 1'b0, 1'b0, 2'b11, 3'd3, 1'b1, 1'b0);
    in_imm = 16'h1234;
    step();
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    read1regsel = 3'd3; rf_read1data = 16'h0000; read2regsel = 3'd4;
    step();

    // HALT without regwrite, then traffic while halted.
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    step();
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'd7, 1'b1, 1'b0);
    step();
    chk("halt_state", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'd1, 3'd4, 1'b1, 1'b0);
      step();
    end
    chk("halt_err", 32'(err), 32'd1);

    // Reset mid-run with valid traffic in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'(i), 3'(i), 1'b1, 1'b0);
      step();
    end
    do_reset();

    // Saturation: 20 back-to-back retires on a 4-bit counter.
    for (int i = 0; i < 21; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 2'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      step();
    end
    chk("sat_retired", 32'(retired), 32'hF);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 9) == 0), 2'($urandom), 3'($urandom),
             1'($urandom), ($urandom_range(0, 39) == 0));
      step();
      if (halted_m && $urandom_range(0, 3) == 0) do_reset();
    end

    // Drain and confirm nothing expected was left unretired.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
      step();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback controller for the 16-bit, 8-entry register file.
- Captures the retiring instruction's results, selects the writeback value, and drives the register file's `writeregsel`/`writedata`/`write` inputs.
- Also tracks halt state, counts retired instructions, and optionally forwards same-cycle write data to the register-file read ports.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  an instruction is presented from the MEM stage.
- stall  in  1  freeze the stage this cycle.
- flush  in  1  discard the incoming instruction.
- in_alu  in  16  ALU result.
- in_mem  in  16  load data.
- in_pcinc  in  16  PC+2, used for link writes.
- in_imm  in  16  immediate, used for load-immediate.
- in_wbsel  in  2  result select: 00 alu, 01 mem, 10 pcinc, 11 imm.
- in_dest  in  3  destination register.
- in_regwrite  in  1  instruction writes a register.
- in_halt  in  1  instruction is HALT.
- read1regsel  in  3  decode read select 1, used for the bypass compare.
- read2regsel  in  3  decode read select 2.
- rf_read1data  in  16  register-file read port 1.
- rf_read2data  in  16  register-file read port 2.
- writeregsel  out  3  to the register file.
- writedata  out  16  to the register file.
- write  out  1  to the register file.
- fwd_read1data  out  16  read data 1 seen by decode.
- fwd_read2data  out  16  read data 2 seen by decode.
- wb_valid  out  1  an instruction retires this cycle.
- halted  out  1  the processor has halted.
- retired  out  CNT_W  retired-instruction count.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1):
  - valid_q=0, all captured fields 0, state=RUN.
  - Outputs: write=0, wb_valid=0, halted=0, err=0, retired=0, writeregsel=0, writedata=0.
- Capture, at each rising edge:
  - flush=1 → valid_q<=0. flush has priority over stall.
  - else stall=1 → all captured fields hold.
  - else state=RUN → capture every in_* field, with valid_q<=in_valid.
  - else (HALTED) → valid_q<=0 and the in_* fields are ignored.
- Retire condition: retire = valid_q & ~stall & (state==RUN). The instruction already in the register retires in the flush cycle if retire holds.
- Output decode from registered fields:
  - wb_valid = retire.
  - write = retire & regwrite_q.
  - writeregsel = dest_q.
  - writedata = mux(wbsel_q): alu_q, mem_q, pcinc_q, imm_q.
- Latency: 1 cycle from capture to write. The register file commits on the following edge, so an in→register-file commit takes 2 edges.
- State machine, RUN / HALTED:
  - RUN→HALTED on an edge where retire & halt_q.
  - HALTED exits only on rst.
  - halted output = (state==HALTED).
  - A HALT with regwrite_q=1 still writes in its retire cycle.
- Counter: retired increments by 1 on each edge where retire=1, and saturates at all-ones (no wrap).
- err: set on an edge where state==HALTED & in_valid; cleared only by rst.
- Stall+flush together: valid_q cleared, no retire that cycle, and the instruction in the register is lost. This is the documented behaviour.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - fwd_readNdata = writedata when write & (writeregsel==readNregsel), else rf_readNdata.
  - Covers the same-cycle read-after-write window of the register file.
- Undefined:
  - fwd_readNdata = rf_readNdata, a pure pass-through.
  - The hazard unit must stall one extra cycle.

Decomposition:
- Shared package wb_pkg:
  - WBSEL_ALU=2'b00, WBSEL_MEM=2'b01, WBSEL_PC=2'b10, WBSEL_IMM=2'b11.
  - State encodings ST_RUN=1'b0, ST_HALT=1'b1.
  - REG_SEL_W=3, DATA_W=16.
- Sub-module wb_fwd:
  - Instantiated twice, one per read port.
  - Inputs: write, writeregsel, writedata, readregsel, rf_data. Output: fwd_data.
  - Its compare logic is present only under WB_BYPASS_EN.

Test Plan:
- Reset mid-run: drive valid traffic, assert rst asynchronously between edges → all outputs 0 immediately, retired=0.
- Basic write: in_valid=1, in_wbsel=01, in_mem=16'hBEEF, in_dest=5, in_regwrite=1 → next cycle write=1, writeregsel=5, writedata=BEEF, wb_valid=1, retired=1.
- Stall/flush:
  - Captured valid instruction with stall held 3 cycles → write=0 for 3 cycles, then write=1 exactly once, and retired increments once.
  - flush with in_valid=1 → no write the following cycle.
- Halt: HALT retires with in_regwrite=0 → halted=1 next edge, and later in_valid=1 gives err=1 sticky, write=0, retired frozen.
- Counter saturation with CNT_W=4: 20 back-to-back retires → retired=4'hF, holds.
- Bypass with WB_BYPASS_EN:
  - write=1, writeregsel=3, writedata=16'h1234, read1regsel=3, rf_read1data=16'h0000 → fwd_read1data=1234.
  - read2regsel=4 → fwd_read2data=rf_read2data.
  - Macro undefined → fwd_read1data=0000.
